// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit start validation, centre sampling.
// Bytes are presented with a one-cycle rx_done strobe; a low stop bit gives a frame_err pulse.
module uart_rx #(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);
  localparam int clks_per_bit = clk_freq / baud_rate;
  localparam int half_bit     = clks_per_bit / 2;
  localparam logic [15:0] bit_last  = 16'(clks_per_bit - 1);
  localparam logic [15:0] half_last = 16'(half_bit - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state;
  logic        s1, rx_s;
  logic [15:0] clk_count;
  logic [2:0]  bit_index;
  logic [7:0]  sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s1        <= 1'b1;
      rx_s      <= 1'b1;
      clk_count <= '0;
      bit_index <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1        <= rx_line;
      rx_s      <= s1;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_count <= '0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (clk_count == half_last) begin
            clk_count <= '0;
            if (!rx_s) begin
              state     <= DATA;
              bit_index <= '0;
            end else begin
              // start bit gone by mid-bit: a glitch, not a frame
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        DATA: begin
          if (clk_count == bit_last) begin
            clk_count <= '0;
            sh        <= {rx_s, sh[7:1]};
            bit_index <= bit_index + 3'd1;
            if (bit_index == 3'd7) state <= STOP;
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        STOP: begin
          if (clk_count == bit_last) begin
            clk_count <= '0;
            if (rx_s) begin
              rx_data <= sh;
              rx_done <= 1'b1;
              rx_busy <= 1'b0;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        BREAK: begin
          // a held-low line must go high before another start edge counts
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clk/bit: frames are driven from bit periods in ns and
// received bytes are compared against a queue of expected good frames.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int PER      = CPB * 10;   // ideal bit period in ns (10 ns clock)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = 0;
  int ferr_cnt = 0;
  int overlap_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
    .clk(clk), .reset(reset), .rx_line(rx_line),
    .rx_data(rx_data), .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle rx_done is high yields one received byte, so a stretched
  // pulse shows up as an extra byte.
  always @(negedge clk) begin
    if (rx_done) begin
      got_q.push_back(rx_data);
      done_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (rx_done && frame_err) overlap_cnt++;
  end

  // Drives one 8N1 frame starting now; stop_hi=0 leaves the line low afterwards.
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int per);
    rx_line = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rx_line = (b >> i) & 8'h01;
      #(per);
    end
    rx_line = stop_hi;
    #(per);
    if (stop_hi) begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    checks++;
    if ({rx_data, rx_done, rx_busy, frame_err} !== 11'h000) begin
      failures++;
      $display("FAIL reset_outputs got data=%h done=%b busy=%b err=%b want all 0",
               rx_data, rx_done, rx_busy, frame_err);
    end
    reset = 1'b0;
    last_good = 8'h00;
    idle(5);
    checks++;
    if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_idle got busy=%b data=%h want busy=0 data=00", rx_busy, rx_data);
    end
  endtask

  task automatic test_single;
    int fall_cyc, e0;
    got_q.delete(); exp_q.delete();
    e0 = ferr_cnt;
    idle(10);
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b1, PER);
    idle(30);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      failures++;
      $display("FAIL single_byte got count=%0d first=%h want count=1 byte=a5",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    // line seen 2 clk late, 1 clk into START, stop decision, then registered strobe
    checks++;
    if (done_cyc - fall_cyc != HALF + 9 * CPB + 3) begin
      failures++;
      $display("FAIL done_latency got %0d want %0d", done_cyc - fall_cyc, HALF + 9 * CPB + 3);
    end
    checks++;
    if (ferr_cnt != e0 || rx_busy !== 1'b0 || rx_data !== last_good) begin
      failures++;
      $display("FAIL single_after got err=%0d busy=%b data=%h want err=0 busy=0 data=%h",
               ferr_cnt - e0, rx_busy, rx_data, last_good);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [3] = '{8'h00, 8'hFF, 8'h55};
    got_q.delete(); exp_q.delete();
    foreach (seq[i]) send_frame(seq[i], 1'b1, PER);
    idle(30);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_glitch;
    int e0;
    got_q.delete();
    e0 = ferr_cnt;
    @(negedge clk);
    rx_line = 1'b0;
    idle(4);
    rx_line = 1'b1;
    idle(10);
    checks++;
    if (rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy got %b want 0", rx_busy);
    end
    idle(200);
    checks++;
    if (got_q.size() != 0 || ferr_cnt != e0) begin
      failures++;
      $display("FAIL glitch_outputs got frames=%0d errs=%0d want 0 0", got_q.size(), ferr_cnt - e0);
    end
  endtask

  task automatic test_frame_err;
    int e0;
    got_q.delete();
    e0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, PER);
    idle(40);
    checks++;
    if (ferr_cnt - e0 != 1) begin
      failures++;
      $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - e0);
    end
    checks++;
    if (rx_busy !== 1'b1 || rx_data !== last_good) begin
      failures++;
      $display("FAIL ferr_hold got busy=%b data=%h want busy=1 data=%h", rx_busy, rx_data, last_good);
    end
    rx_line = 1'b1;
    idle(200);
    checks++;
    if (rx_busy !== 1'b0 || got_q.size() != 0 || ferr_cnt - e0 != 1) begin
      failures++;
      $display("FAIL ferr_release got busy=%b frames=%0d errs=%0d want 0 0 1",
               rx_busy, got_q.size(), ferr_cnt - e0);
    end
    checks++;
    if (overlap_cnt != 0) begin
      failures++;
      $display("FAIL done_err_overlap got %0d want 0", overlap_cnt);
    end
  endtask

  task automatic test_reset_midframe;
    got_q.delete(); exp_q.delete();
    fork
      send_frame(8'hC3, 1'b1, PER);
      begin
        #(PER * 5 + PER / 2);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        checks++;
        if ({rx_data, rx_done, rx_busy, frame_err} !== 11'h000) begin
          failures++;
          $display("FAIL midframe_reset got data=%h done=%b busy=%b err=%b want all 0",
                   rx_data, rx_done, rx_busy, frame_err);
        end
      end
    join
    exp_q.delete();   // the C3 frame was cut by reset
    last_good = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(5);
    checks++;
    if (got_q.size() != 0 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL partial_dropped got frames=%0d data=%h want 0 00", got_q.size(), rx_data);
    end
    send_frame(8'h81, 1'b1, PER);
    idle(30);
    checks++;
    if (got_q.size() != 1 || rx_data !== 8'h81) begin
      failures++;
      $display("FAIL after_reset got frames=%0d data=%h want 1 81", got_q.size(), rx_data);
    end
  endtask

  task automatic test_baud_tolerance;
    int pers [2] = '{PER - PER / 32, PER + PER / 32};   // 15.5 and 16.5 clk bits
    int e0;
    foreach (pers[p]) begin
      got_q.delete();
      e0 = ferr_cnt;
      send_frame(8'h96, 1'b1, pers[p]);
      idle(30);
      checks++;
      if (got_q.size() != 1 || rx_data !== 8'h96 || ferr_cnt != e0) begin
        failures++;
        $display("FAIL baud_%0dns got frames=%0d data=%h errs=%0d want 1 96 0",
                 pers[p], got_q.size(), rx_data, ferr_cnt - e0);
      end
    end
  endtask

  task automatic test_random;
    int per, gap;
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      per = PER - 5 + 5 * int'($urandom_range(0, 2));
      gap = $urandom_range(0, 2);
      send_frame(8'($urandom), 1'b1, per);
      #(gap * per);
    end
    idle(30);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (rx_data !== last_good) begin
      failures++;
      $display("FAIL rand_last got %h want %h", rx_data, last_good);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_baud_tolerance();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
